id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage MIPS core, placed directly upstream of `alu`. It registers decoded operands and control from decode, and produces the final ALU operands `a`, `b` and `alucont`. Operand generation covers immediate extension and forwarding from EX/MEM and MEM/WB. The block also detects load-use hazards and stalls decode while inserting bubbles into execute.

---
 rtl/id_ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core, feeding the ALU.
//
// Captures decoded operands/control, extends the immediate at capture, and builds
// the final ALU operands with EX/MEM and MEM/WB forwarding. Detects load-use
// hazards, stalling decode and inserting a bubble into EX.
//
// Build option: define ID_EX_FORWARD_EN to enable forwarding. Without it the
// operands come straight from the registered data and every RAW dependence on
// an instruction still in EX or EX/MEM stalls instead.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   freeze, flush                    downstream stall, squash of the entering instr
//   id_*                             decoded instruction from the ID stage
//   exm_regwrite/wr_addr/result      EX/MEM forward source
//   wb_regwrite/wr_addr/data         MEM/WB forward source
//   id_stall                         hold PC and IF/ID this cycle
//   ex_valid, ex_a, ex_b, ex_rt_fwd  EX slot valid, ALU operands, store data
//   ex_alucont, ex_wr_addr           registered control
//   ex_regwrite, ex_memtoreg         registered control, gated by ex_valid
module id_ex_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        freeze,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic        id_alusrc,
    input  logic        id_zeroext,
    input  logic [5:0]  id_alucont,
    input  logic [4:0]  id_wr_addr,
    input  logic        id_regwrite,
    input  logic        id_memtoreg,
    input  logic        exm_regwrite,
    input  logic [4:0]  exm_wr_addr,
    input  logic [31:0] exm_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_wr_addr,
    input  logic [31:0] wb_data,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_rt_fwd,
    output logic [5:0]  ex_alucont,
    output logic [4:0]  ex_wr_addr,
    output logic        ex_regwrite,
    output logic        ex_memtoreg
);

    logic        valid_q, valid_d;
    logic [4:0]  rs_addr_q, rs_addr_d;
    logic [4:0]  rt_addr_q, rt_addr_d;
    logic [31:0] rs_data_q, rs_data_d;
    logic [31:0] rt_data_q, rt_data_d;
    logic [31:0] imm_q, imm_d;
    logic        alusrc_q, alusrc_d;
    logic [5:0]  alucont_q, alucont_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        uses_rs_q, uses_rs_d;
    logic        uses_rt_q, uses_rt_d;

    logic        hazard;
    logic        id_dep_ex;
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;

    // ID instruction reads the register the EX instruction writes.
    assign id_dep_ex = id_valid &
                       ((id_uses_rs & (id_rs_addr == wr_addr_q)) |
                        (id_uses_rt & (id_rt_addr == wr_addr_q)));

`ifdef ID_EX_FORWARD_EN
    // Only a load in EX cannot be covered by forwarding; everything else resolves
    // from EX/MEM or MEM/WB next cycle.
    assign hazard = valid_q & memtoreg_q & (wr_addr_q != 5'd0) & id_dep_ex;

    always_comb begin
        rs_fwd = rs_data_q;
        if (exm_regwrite && (rs_addr_q != 5'd0) && (exm_wr_addr == rs_addr_q)) begin
            rs_fwd = exm_result;
        end else if (wb_regwrite && (rs_addr_q != 5'd0) && (wb_wr_addr == rs_addr_q)) begin
            rs_fwd = wb_data;
        end
    end

    always_comb begin
        rt_fwd = rt_data_q;
        if (exm_regwrite && (rt_addr_q != 5'd0) && (exm_wr_addr == rt_addr_q)) begin
            rt_fwd = exm_result;
        end else if (wb_regwrite && (rt_addr_q != 5'd0) && (wb_wr_addr == rt_addr_q)) begin
            rt_fwd = wb_data;
        end
    end

    logic unused_sink;
    assign unused_sink = ^{uses_rs_q, uses_rt_q};
`else
    logic id_dep_exm;
    assign id_dep_exm = id_valid &
                        ((id_uses_rs & (id_rs_addr == exm_wr_addr)) |
                         (id_uses_rt & (id_rt_addr == exm_wr_addr)));

    // No forwarding: wait until the producer has reached WB, whose write the
    // register file passes through to the same-cycle read.
    assign hazard = (valid_q & regwrite_q & (wr_addr_q != 5'd0) & id_dep_ex) |
                    (exm_regwrite & (exm_wr_addr != 5'd0) & id_dep_exm);

    assign rs_fwd = rs_data_q;
    assign rt_fwd = rt_data_q;

    logic unused_sink;
    assign unused_sink = ^{uses_rs_q, uses_rt_q, rs_addr_q, rt_addr_q, exm_result,
                           wb_regwrite, wb_wr_addr, wb_data};
`endif

    assign id_stall = freeze | (hazard & ~flush);

    always_comb begin
        valid_d    = valid_q;
        rs_addr_d  = rs_addr_q;
        rt_addr_d  = rt_addr_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        alusrc_d   = alusrc_q;
        alucont_d  = alucont_q;
        wr_addr_d  = wr_addr_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        uses_rs_d  = uses_rs_q;
        uses_rt_d  = uses_rt_q;
        if (!freeze) begin
            // Fields are captured even on flush/bubble; valid=0 makes them inert.
            valid_d    = id_valid & ~flush & ~hazard;
            rs_addr_d  = id_rs_addr;
            rt_addr_d  = id_rt_addr;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_zeroext ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};
            alusrc_d   = id_alusrc;
            alucont_d  = id_alucont;
            wr_addr_d  = id_wr_addr;
            regwrite_d = id_regwrite;
            memtoreg_d = id_memtoreg;
            uses_rs_d  = id_uses_rs;
            uses_rt_d  = id_uses_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            rs_addr_q  <= 5'd0;
            rt_addr_q  <= 5'd0;
            rs_data_q  <= 32'd0;
            rt_data_q  <= 32'd0;
            imm_q      <= 32'd0;
            alusrc_q   <= 1'b0;
            alucont_q  <= 6'd0;
            wr_addr_q  <= 5'd0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            uses_rs_q  <= 1'b0;
            uses_rt_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs_addr_q  <= rs_addr_d;
            rt_addr_q  <= rt_addr_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            alusrc_q   <= alusrc_d;
            alucont_q  <= alucont_d;
            wr_addr_q  <= wr_addr_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            uses_rs_q  <= uses_rs_d;
            uses_rt_q  <= uses_rt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_a        = rs_fwd;
    assign ex_rt_fwd   = rt_fwd;
    assign ex_b        = alusrc_q ? imm_q : rt_fwd;
    assign ex_alucont  = alucont_q;
    assign ex_wr_addr  = wr_addr_q;
    assign ex_regwrite = valid_q & regwrite_q;
    assign ex_memtoreg = valid_q & memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Each cycle the bench drives ID/forward inputs,
// checks the EX state against the scoreboard head, and pushes what the next edge
// must produce (capture, bubble, hold or reset).
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    localparam int KCap  = 0;
    localparam int KBub  = 1;
    localparam int KHold = 2;
    localparam int KRst  = 3;

    logic        clk = 1'b0;
    logic        reset_n, freeze, flush;
    logic        id_valid, id_uses_rs, id_uses_rt, id_alusrc, id_zeroext;
    logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic [5:0]  id_alucont;
    logic        id_regwrite, id_memtoreg;
    logic        exm_regwrite, wb_regwrite;
    logic [4:0]  exm_wr_addr, wb_wr_addr;
    logic [31:0] exm_result, wb_data;
    logic        id_stall, ex_valid, ex_regwrite, ex_memtoreg;
    logic [31:0] ex_a, ex_b, ex_rt_fwd;
    logic [5:0]  ex_alucont;
    logic [4:0]  ex_wr_addr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          care;
        bit          v;
        logic [4:0]  rs_addr, rt_addr, wr;
        logic [31:0] rsd, rtd, imm;
        bit          alusrc, rw, mr;
        logic [5:0]  ac;
    } ent_t;

    ent_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_zeroext(id_zeroext), .id_alucont(id_alucont),
        .id_wr_addr(id_wr_addr), .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
        .exm_regwrite(exm_regwrite), .exm_wr_addr(exm_wr_addr), .exm_result(exm_result),
        .wb_regwrite(wb_regwrite), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_rt_fwd(ex_rt_fwd), .ex_alucont(ex_alucont), .ex_wr_addr(ex_wr_addr),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference forwarding: EX/MEM over MEM/WB, never for $0.
    function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] d);
        if (Fwd && a != 5'd0 && exm_regwrite && exm_wr_addr == a) return exm_result;
        if (Fwd && a != 5'd0 && wb_regwrite && wb_wr_addr == a) return wb_data;
        return d;
    endfunction

    task automatic check_ex(input ent_t e);
        logic [31:0] ea, er;
        chk("ex_valid", ex_valid, e.v);
        chk("ex_regwrite", ex_regwrite, e.v & e.rw);
        chk("ex_memtoreg", ex_memtoreg, e.v & e.mr);
        if (e.care) begin
            ea = mfwd(e.rs_addr, e.rsd);
            er = mfwd(e.rt_addr, e.rtd);
            chk("ex_a", ex_a, ea);
            chk("ex_rt_fwd", ex_rt_fwd, er);
            chk("ex_b", ex_b, e.alusrc ? e.imm : er);
            chk("ex_alucont", ex_alucont, e.ac);
            chk("ex_wr_addr", ex_wr_addr, e.wr);
        end
    endtask

    task automatic set_id(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                          input bit urs, input bit urt, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic [15:0] imm, input bit asrc,
                          input bit zext, input logic [5:0] ac, input logic [4:0] wr,
                          input bit rw, input bit mr);
        id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_uses_rs = urs;
        id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alusrc = asrc; id_zeroext = zext; id_alucont = ac; id_wr_addr = wr;
        id_regwrite = rw; id_memtoreg = mr;
    endtask

    task automatic idle_id();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_fwd(input bit erw, input logic [4:0] ea, input logic [31:0] ed,
                           input bit wrw, input logic [4:0] wa, input logic [31:0] wd);
        exm_regwrite = erw; exm_wr_addr = ea; exm_result = ed;
        wb_regwrite = wrw; wb_wr_addr = wa; wb_data = wd;
    endtask

    // One cycle: inputs already driven; check state and stall, predict next edge.
    task automatic cyc(input int kind, input bit exp_stall);
        ent_t cur, nxt;
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            cur = sb.pop_front();
            check_ex(cur);
            chk("id_stall", id_stall, exp_stall);
        end
        nxt = '{default: '0};
        case (kind)
            KCap: begin
                nxt.care = 1; nxt.v = id_valid; nxt.rs_addr = id_rs_addr;
                nxt.rt_addr = id_rt_addr; nxt.rsd = id_rs_data; nxt.rtd = id_rt_data;
                nxt.imm = id_zeroext ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};
                nxt.alusrc = id_alusrc; nxt.ac = id_alucont; nxt.wr = id_wr_addr;
                nxt.rw = id_regwrite; nxt.mr = id_memtoreg;
            end
            KBub:  nxt.care = 0;
            KHold: nxt = cur;
            default: nxt.care = 1;
        endcase
        sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ent_t z;
        reset_n = 0; freeze = 0; flush = 0;
        idle_id();
        set_fwd(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        z = '{default: '0};
        z.care = 1;
        sb.push_back(z);
        cyc(KRst, 0);
        reset_n = 1;
        cyc(KCap, 0);
        // ADDI sign-extended, then ORI zero-extended with the same immediate
        set_id(1, 1, 2, 1, 0, 32'd10, 0, 16'hFFFF, 1, 0, 6'h20, 2, 1, 0);
        cyc(KCap, 0);
        set_id(1, 1, 2, 1, 0, 32'd10, 0, 16'hFFFF, 1, 1, 6'h25, 3, 1, 0);
        cyc(KCap, 0);
        // ADD $7 = $5 + $6, then EX/MEM and WB both supply $5
        set_id(1, 5, 6, 1, 1, 32'd9, 32'd7, 0, 0, 0, 6'h20, 7, 1, 0);
        cyc(KCap, 0);
        set_fwd(1, 5, 32'h1234, 1, 5, 32'hAAAA);
        set_id(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6'h21, 8, 1, 0);
        cyc(KCap, 0);
        set_fwd(1, 0, 32'h1234, 1, 0, 32'hAAAA);
        idle_id();
        cyc(KCap, 0);
        // Load-use: LW $3 then ADD reading rt=$3
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 1, 0, 32'd100, 0, 16'd4, 1, 0, 6'h20, 3, 1, 1);
        cyc(KCap, 0);
        set_id(1, 2, 3, 1, 1, 32'd50, 0, 0, 0, 0, 6'h20, 9, 1, 0);
        cyc(KBub, 1);
`ifdef ID_EX_FORWARD_EN
        set_fwd(1, 3, 32'h104, 0, 0, 0);
        cyc(KCap, 0);
        set_fwd(0, 0, 0, 1, 3, 32'hBEEF);
        idle_id();
        cyc(KCap, 0);
`else
        set_fwd(1, 3, 32'h104, 0, 0, 0);
        cyc(KBub, 1);
        set_fwd(0, 0, 0, 1, 3, 32'hBEEF);
        set_id(1, 2, 3, 1, 1, 32'd50, 32'hBEEF, 0, 0, 0, 6'h20, 9, 1, 0);
        cyc(KCap, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        idle_id();
        cyc(KCap, 0);
`endif
        // Flush with a simultaneous load-use hazard
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 1, 0, 32'd200, 0, 16'd8, 1, 0, 6'h20, 4, 1, 1);
        cyc(KCap, 0);
        set_id(1, 4, 0, 1, 0, 32'd1, 0, 0, 0, 0, 6'h20, 11, 1, 0);
        flush = 1;
        cyc(KBub, 0);
        flush = 0;
        idle_id();
        cyc(KCap, 0);
        // Freeze holds everything and stalls decode
        set_id(1, 5, 6, 1, 1, 32'h11, 32'h22, 0, 0, 0, 6'h22, 10, 1, 0);
        cyc(KCap, 0);
        freeze = 1;
        set_id(1, 7, 8, 1, 1, 32'd1, 32'd2, 16'd3, 1, 1, 6'h3F, 12, 1, 1);
        cyc(KHold, 1);
        cyc(KHold, 1);
        freeze = 0;
        idle_id();
        cyc(KCap, 0);
        // ADD $4 followed by SUB reading $4
        set_id(1, 1, 2, 1, 1, 32'd3, 32'd4, 0, 0, 0, 6'h20, 4, 1, 0);
        cyc(KCap, 0);
`ifdef ID_EX_FORWARD_EN
        set_id(1, 4, 5, 1, 1, 0, 32'd6, 0, 0, 0, 6'h22, 13, 1, 0);
        cyc(KCap, 0);
        set_fwd(1, 4, 32'h77, 0, 0, 0);
        idle_id();
        cyc(KCap, 0);
`else
        set_id(1, 4, 5, 1, 1, 0, 32'd6, 0, 0, 0, 6'h22, 13, 1, 0);
        cyc(KBub, 1);
        set_fwd(1, 4, 32'h77, 0, 0, 0);
        cyc(KBub, 1);
        set_fwd(0, 0, 0, 1, 4, 32'h77);
        set_id(1, 4, 5, 1, 1, 32'h77, 32'd6, 0, 0, 0, 6'h22, 13, 1, 0);
        cyc(KCap, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        idle_id();
        cyc(KCap, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
